// File: rtl/mult_arb_pkg.sv
// Shared types and default sizing for the multiplier arbiter and its round-robin picker.
package mult_arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_SZ   = 32;
    localparam int DEF_CNTW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after last_i, wrapping, that has req_i set.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [IDW-1:0]  grant_o,
    output logic            any_o
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        sum     = '0;
        idx     = '0;
        // Offsets 1..NREQ, so last_i itself is considered only after everyone else.
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last_i} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!any_o && req_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one external multiplier among NREQ requesters.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int SZ   = DEF_SZ,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = DEF_CNTW
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*SZ-1:0] req_a,
    input  logic [NREQ*SZ-1:0] req_b,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [2*SZ-1:0]   resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic [SZ-1:0]     mul_a,
    output logic [SZ-1:0]     mul_b,
    output logic              mul_start,
    input  logic              mul_ready,
    input  logic [2*SZ-1:0]   mul_res,
    output logic              busy,
    output logic [CNTW-1:0]   jobs_done,
    output state_e            dbg_state
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; req_ready is only offered in IDLE while the multiplier is idle,
    // and resp_valid is held with stable data until the owner's resp_ready.

    state_e            state_q, state_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [SZ-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    logic [2*SZ-1:0]   resp_data_q, resp_data_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic              mul_start_q, mul_start_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   jobs_done_q, jobs_done_d;
    logic              skip_q, skip_d;

    logic [IDW-1:0]    pick_grant;
    logic              pick_any;
    logic [SZ-1:0]     a_slice [NREQ];
    logic [SZ-1:0]     b_slice [NREQ];

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            a_slice[k] = req_a[k*SZ +: SZ];
            b_slice[k] = req_b[k*SZ +: SZ];
        end
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        jobs_done_d  = jobs_done_q;
        skip_d       = skip_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (pick_any && mul_ready) begin
                    req_ready[pick_grant] = 1'b1;
                    mul_a_d   = a_slice[pick_grant];
                    mul_b_d   = b_slice[pick_grant];
                    resp_id_d = pick_grant;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                skip_d  = 1'b1;
            end
            WAIT: begin
                // The multiplier may still report ready in the cycle after start.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (mul_ready) begin
                    resp_data_d             = mul_res;
                    resp_valid_d            = '0;
                    resp_valid_d[resp_id_q] = 1'b1;
                    state_d                 = RESP;
                end
            end
            RESP: begin
                if (resp_ready[resp_id_q]) begin
                    resp_valid_d = '0;
                    last_d       = resp_id_q;
                    jobs_done_d  = jobs_done_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mul_start_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NREQ - 1);
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= '0;
            mul_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            jobs_done_q  <= '0;
            skip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            mul_start_q  <= mul_start_d;
            busy_q       <= busy_d;
            jobs_done_q  <= jobs_done_d;
            skip_q       <= skip_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_start  = mul_start_q;
    assign busy       = busy_q;
    assign jobs_done  = jobs_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a fixed-latency behavioural multiplier.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int SZ   = 32;
    localparam int IDW  = 2;
    localparam int CNTW = 4;  // narrow counter so the wrap is reachable in a short run
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              _rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*SZ-1:0] req_a, req_b;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [2*SZ-1:0]   resp_data;
    logic [IDW-1:0]    resp_id;
    logic [SZ-1:0]     mul_a, mul_b;
    logic              mul_start;
    logic              mul_ready;
    logic [2*SZ-1:0]   mul_res;
    logic              busy;
    logic [CNTW-1:0]   jobs_done;
    state_e            dbg_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int mul_cnt;
    logic [NREQ-1:0] oneshot = '0;
    logic [NREQ-1:0] acc;
    logic [IDW+2*SZ-1:0] exp_q[$];

    mult_arbiter #(.NREQ(NREQ), .SZ(SZ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), ._rst(_rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .mul_a(mul_a), .mul_b(mul_b),
        .mul_start(mul_start), .mul_ready(mul_ready), .mul_res(mul_res),
        .busy(busy), .jobs_done(jobs_done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural multiplier: drops ready on start, returns product LAT cycles later
    always @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            mul_ready <= 1'b1;
            mul_cnt   <= 0;
            mul_res   <= '0;
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            mul_cnt   <= LAT;
        end else if (!mul_ready) begin
            if (mul_cnt == 1) begin
                mul_ready <= 1'b1;
                mul_res   <= {32'd0, mul_a} * {32'd0, mul_b};
            end
            mul_cnt <= mul_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        if (mul_start) start_cnt++;
        if (_rst && resp_valid != '0 && resp_ready[resp_id]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual_id=%0d data=0x%0h required=none", resp_id, resp_data);
            end else begin
                logic [IDW+2*SZ-1:0] e;
                e = exp_q.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e[IDW+2*SZ-1:2*SZ]));
                chk("resp_valid", 64'(resp_valid), 64'(4'b0001 << e[IDW+2*SZ-1:2*SZ]));
                chk("resp_data", resp_data, e[2*SZ-1:0]);
            end
        end
    end

    // drops a one-shot requester's valid right after its accept
    always begin
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(acc & oneshot);
    end

    // driver tasks
    task automatic do_reset();
        @(posedge clk); #1;
        _rst = 1'b0;
        req_valid = '0;
        resp_ready = '1;
        oneshot = '0;
        repeat (2) @(posedge clk);
        #1 _rst = 1'b1;
    endtask

    task automatic set_ops(input int id, input logic [SZ-1:0] a, input logic [SZ-1:0] b);
        req_a[id*SZ +: SZ] = a;
        req_b[id*SZ +: SZ] = b;
    endtask

    task automatic push_exp(input int id, input logic [2*SZ-1:0] p);
        logic [IDW-1:0] i;
        i = IDW'(id);
        exp_q.push_back({i, p});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual_pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_data"}, resp_data, 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
        chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
        chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_jobs_done"}, 64'(jobs_done), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        int n;
        int s0;
        _rst = 1'b0;
        req_valid = '0;
        resp_ready = '1;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1 _rst = 1'b1;

        // single job from requester 0
        s0 = start_cnt;
        oneshot = 4'b1111;
        set_ops(0, 32'd7, 32'd6);
        push_exp(0, 64'd42);
        req_valid[0] = 1'b1;
        wait_drain("single");
        @(negedge clk);
        chk("single_start_pulses", 64'(start_cnt - s0), 64'd1);
        chk("single_jobs_done", 64'(jobs_done), 64'd1);
        chk("single_mul_a", 64'(mul_a), 64'd7);
        chk("single_mul_b", 64'(mul_b), 64'd6);

        // all four at once, served 0,1,2,3
        do_reset();
        oneshot = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 32'(i + 1), 32'd100);
            push_exp(i, 64'((i + 1) * 100));
        end
        req_valid = 4'b1111;
        wait_drain("all4");
        @(negedge clk);
        chk("all4_jobs_done", 64'(jobs_done), 64'd4);

        // 1 and 3 held valid: 1,3,1,3,1
        do_reset();
        set_ops(1, 32'd11, 32'd3);
        set_ops(3, 32'd13, 32'd5);
        for (int k = 0; k < 5; k++) push_exp((k % 2 == 0) ? 1 : 3, (k % 2 == 0) ? 64'd33 : 64'd65);
        req_valid = 4'b1010;
        wait_drain("fair");
        @(posedge clk); #1 req_valid = '0;

        // response stall on requester 2 while requester 0 waits
        oneshot = 4'b0101;
        resp_ready = 4'b1011;
        set_ops(2, 32'hFFFF_FFFF, 32'd2);
        set_ops(0, 32'd9, 32'd9);
        push_exp(2, 64'h1_FFFF_FFFE);
        push_exp(0, 64'd81);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        n = 0;
        while (resp_valid == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 20; c++) begin
            chk("stall_resp_valid", 64'(resp_valid), 64'h4);
            chk("stall_resp_data", resp_data, 64'h1_FFFF_FFFE);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1 resp_ready = '1;
        wait_drain("stall");

        // reset while waiting on the multiplier: job dropped, next job runs normally
        do_reset();
        oneshot = 4'b1111;
        set_ops(1, 32'd5, 32'd5);
        req_valid[1] = 1'b1;
        n = 0;
        while (dbg_state != WAIT && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_wait", 64'(dbg_state), 64'(WAIT));
        _rst = 1'b0;
        req_valid = '0;
        #2;
        chk_reset("midrst");
        @(posedge clk); #1 _rst = 1'b1;
        repeat (8) @(negedge clk);
        set_ops(0, 32'd3, 32'd4);
        push_exp(0, 64'd12);
        req_valid[0] = 1'b1;
        wait_drain("after_rst");
        @(negedge clk);
        chk("after_rst_jobs_done", 64'(jobs_done), 64'd1);

        // counter wrap
        do_reset();
        oneshot = 4'b1111;
        for (int j = 1; j <= 17; j++) begin
            set_ops(2, 32'(j), 32'd3);
            push_exp(2, 64'(j * 3));
            req_valid[2] = 1'b1;
            wait_drain("wrap");
            @(negedge clk);
            if (j >= 15) chk("wrap_jobs_done", 64'(jobs_done), 64'(j % 16));
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
